rv_decode_stage: RTL and testbench

Registered RV32I(M) instruction decode stage with a valid/ready handshake on both sides. It accepts raw 32-bit instructions plus PC from fetch and presents the ALU-facing fields: opcode, func3, func7, register indices, format-specific sign-extended immediate, and an illegal flag. The output path has a one-entry skid buffer, so fetch back-pressure never combinationally depends on `out_ready`.

---
 rtl/rv_decode_stage.sv | 172 +++++++++++++++++
 tb/tb_rv_decode_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage.sv
// RV32I(M) registered decode stage with valid/ready on both sides and a one-entry output skid.
// Optional feature macro: RV_DECODE_M_EXT_EN (M-extension OP encodings are legal when defined).
module rv_decode_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcJal    = 7'b1101111;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } bundle_t;

    bundle_t    dec;
    bundle_t    main_d, main_q, skid_d, skid_q;
    logic       main_valid_d, main_valid_q, skid_valid_d, skid_valid_q;
    logic       accept, drain;
    logic [6:0] f7_raw;

    assign f7_raw = in_instr[31:25];

    always_comb begin
        dec         = '0;
        dec.opcode  = in_instr[6:0];
        dec.func3   = in_instr[14:12];
        dec.rd      = in_instr[11:7];
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.pc      = in_pc;
        case (dec.opcode)
            OpcOpImm: begin
                if (dec.func3 == 3'b001 || dec.func3 == 3'b101) begin
                    dec.func7   = f7_raw;
                    dec.imm     = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                    dec.illegal = (dec.func3 == 3'b001) ? (f7_raw != 7'b0000000)
                                : !(f7_raw == 7'b0000000 || f7_raw == 7'b0100000);
                end else begin
                    dec.imm = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                end
            end
            OpcLoad: begin
                dec.imm     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                dec.illegal = (dec.func3 == 3'b011) || (dec.func3 == 3'b110)
                           || (dec.func3 == 3'b111);
            end
            OpcJalr: begin
                dec.imm     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                dec.illegal = (dec.func3 != 3'b000);
            end
            OpcStore: begin
                dec.imm     = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                dec.illegal = (dec.func3 > 3'b010);
            end
            OpcBranch: begin
                dec.imm     = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
                dec.illegal = (dec.func3 == 3'b010) || (dec.func3 == 3'b011);
            end
            OpcLui, OpcAuipc: begin
                dec.imm = {{(XLEN-32){in_instr[31]}}, in_instr[31:12], 12'b0};
            end
            OpcJal: begin
                dec.imm = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            end
            OpcOp: begin
                dec.func7 = f7_raw;
                case (f7_raw)
                    7'b0000000: dec.illegal = 1'b0;
                    7'b0100000: dec.illegal = !(dec.func3 == 3'b000 || dec.func3 == 3'b101);
`ifdef RV_DECODE_M_EXT_EN
                    7'b0000001: dec.illegal = 1'b0;
`else
                    7'b0000001: dec.illegal = 1'b1;
`endif
                    default:    dec.illegal = 1'b1;
                endcase
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign in_ready = !skid_valid_q;
    assign accept   = in_valid && !skid_valid_q;
    assign drain    = main_valid_q && out_ready;

    // Skid has priority for refilling main so order stays FIFO; in_ready is low while it is full.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_opcode  = main_q.opcode;
    assign out_func3   = main_q.func3;
    assign out_func7   = main_q.func7;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_imm     = main_q.imm;
    assign out_pc      = main_q.pc;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: decode vector table, back-pressure, flush and async reset.
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  out_opcode;
    logic [2:0]  out_func3;
    logic [6:0]  out_func7;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_decode_stage #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_func3  (out_func3),
        .out_func7  (out_func7),
        .out_rd     (out_rd),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .out_imm    (out_imm),
        .out_pc     (out_pc),
        .out_illegal(out_illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs[NVEC];

`ifdef RV_DECODE_M_EXT_EN
    localparam logic MulIll = 1'b0;
`else
    localparam logic MulIll = 1'b1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_vec(input vec_t v, input logic [31:0] pc);
        check($sformatf("valid %08h", v.instr), {31'b0, out_valid}, 32'd1);
        check($sformatf("opcode %08h", v.instr), {25'b0, out_opcode}, {25'b0, v.opc});
        check($sformatf("func3 %08h", v.instr), {29'b0, out_func3}, {29'b0, v.f3});
        check($sformatf("func7 %08h", v.instr), {25'b0, out_func7}, {25'b0, v.f7});
        check($sformatf("rd %08h", v.instr), {27'b0, out_rd}, {27'b0, v.rd});
        check($sformatf("rs1 %08h", v.instr), {27'b0, out_rs1}, {27'b0, v.rs1});
        check($sformatf("rs2 %08h", v.instr), {27'b0, out_rs2}, {27'b0, v.rs2});
        check($sformatf("imm %08h", v.instr), out_imm, v.imm);
        check($sformatf("pc %08h", v.instr), out_pc, pc);
        check($sformatf("illegal %08h", v.instr), {31'b0, out_illegal}, {31'b0, v.ill});
    endtask

    // ADDI xk,x0,k with pc tag, used for the ordering sequences.
    function automatic logic [31:0] addi(input int k);
        return 32'h0000_0013 | (32'(k) << 20) | (32'(k) << 7);
    endfunction

    initial begin
        int idx_in, idx_out;
        logic flowing;

        vecs[0]  = '{32'h00500093, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0,  5'd5,  32'h00000005, 1'b0};
        vecs[1]  = '{32'h402081B3, 7'h33, 3'd0, 7'h20, 5'd3,  5'd1,  5'd2,  32'h00000000, 1'b0};
        vecs[2]  = '{32'h022081B3, 7'h33, 3'd0, 7'h01, 5'd3,  5'd1,  5'd2,  32'h00000000, MulIll};
        vecs[3]  = '{32'hFE000EE3, 7'h63, 3'd0, 7'h00, 5'd29, 5'd0,  5'd0,  32'hFFFFFFFC, 1'b0};
        vecs[4]  = '{32'h123452B7, 7'h37, 3'd5, 7'h00, 5'd5,  5'd8,  5'd3,  32'h12345000, 1'b0};
        vecs[5]  = '{32'h4030D093, 7'h13, 3'd5, 7'h20, 5'd1,  5'd1,  5'd3,  32'h00000003, 1'b0};
        vecs[6]  = '{32'hFFFFFFFF, 7'h7F, 3'd7, 7'h00, 5'd31, 5'd31, 5'd31, 32'h00000000, 1'b1};
        vecs[7]  = '{32'h0000B003, 7'h03, 3'd3, 7'h00, 5'd0,  5'd1,  5'd0,  32'h00000000, 1'b1};
        vecs[8]  = '{32'h008000EF, 7'h6F, 3'd0, 7'h00, 5'd1,  5'd0,  5'd8,  32'h00000008, 1'b0};
        vecs[9]  = '{32'h0020A623, 7'h23, 3'd2, 7'h00, 5'd12, 5'd1,  5'd2,  32'h0000000C, 1'b0};
        // SRAI-style encoding under func3 001 with func7 0100000: illegal slli
        vecs[10] = '{32'h40309093, 7'h13, 3'd1, 7'h20, 5'd1,  5'd1,  5'd3,  32'h00000003, 1'b1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        #12;
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset imm", out_imm, 32'd0);
        check("reset pc", out_pc, 32'd0);
        check("reset illegal", {31'b0, out_illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back decode stream with out_ready held high.
        for (int i = 0; i <= NVEC; i++) begin
            @(negedge clk);
            if (i > 0) check_vec(vecs[i-1], 32'h1000 + 32'(4 * (i - 1)));
            if (i < NVEC) begin
                in_valid = 1'b1;
                in_instr = vecs[i].instr;
                in_pc    = 32'h1000 + 32'(4 * i);
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("idle out_valid", {31'b0, out_valid}, 32'd0);

        // Back-pressure: consumer stalls for three cycles while four instructions are offered.
        idx_in = 0; idx_out = 0; flowing = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 3);
            in_valid  = (idx_in < 4);
            in_instr  = addi(idx_in + 1);
            in_pc     = 32'h2000 + 32'(4 * idx_in);
            if (cyc == 2) begin
                check("bp accepted before stall", 32'(idx_in), 32'd2);
                check("bp in_ready low", {31'b0, in_ready}, 32'd0);
            end
            if (flowing && idx_out < 4)
                check("bp no gap", {31'b0, out_valid}, 32'd1);
            if (out_valid && out_ready) begin
                check("bp order pc", out_pc, 32'h2000 + 32'(4 * idx_out));
                check("bp order rd", {27'b0, out_rd}, 32'(idx_out + 1));
                idx_out++;
                flowing = 1'b1;
            end
            if (in_valid && in_ready) idx_in++;
        end
        in_valid = 1'b0;
        check("bp all emerged", 32'(idx_out), 32'd4);

        // Flush with main and skid full and an input offered.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = addi(7); in_pc = 32'h3000;
        @(negedge clk);
        in_instr = addi(8); in_pc = 32'h3004;
        @(negedge clk);
        check("pre-flush in_ready", {31'b0, in_ready}, 32'd0);
        flush = 1'b1; in_instr = addi(9); in_pc = 32'h3008;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush out_valid", {31'b0, out_valid}, 32'd0);
        check("flush in_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        check("flush stays empty", {31'b0, out_valid}, 32'd0);

        // Flush with main full and in_ready high discards the same-cycle input.
        in_valid = 1'b1; in_instr = addi(10); in_pc = 32'h4000; out_ready = 1'b0;
        @(negedge clk);
        flush = 1'b1; in_instr = addi(11); in_pc = 32'h4004;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush2 out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("flush2 input dropped", {31'b0, out_valid}, 32'd0);

        // New instruction after flush, then async reset between edges.
        in_valid = 1'b1; in_instr = vecs[4].instr; in_pc = 32'h5000;
        @(negedge clk);
        in_instr = vecs[0].instr; in_pc = 32'h5004;
        check("post-flush pc", out_pc, 32'h5000);
        check("post-flush imm", out_imm, 32'h12345000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'd0);
        check("async rst imm", out_imm, 32'd0);
        check("async rst pc", out_pc, 32'd0);
        check("async rst rd", {27'b0, out_rd}, 32'd0);
        check("async rst in_ready", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after rst out_valid", {31'b0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
